// File: rtl/disp_scan_capture.sv
// Receiver for a multiplexed 8-digit active-low 7-segment bus: settles on each lit digit,
// decodes it back to hex and publishes whole frames. Optional macro DISP_CAP_STABLE_EN.
module disp_scan_capture #(
  parameter int unsigned SETTLE_CNT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SMP_CE,
  input  logic [7:0]  AN,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        DP,
  output logic [31:0] HEX_OUT,
  output logic [7:0]  DP_OUT,
  output logic [7:0]  OFF_OUT,
  output logic [7:0]  BAD_OUT,
  output logic        FRAME_VLD,
  output logic        ERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      cnt_inc;

  logic [7:0]      an_s_q, an_prev_q;
  logic [6:0]      seg_s_q;
  logic            dp_s_q;

  logic [7:0]      mask_q, mask_d, mask_set;
  logic [7:0][3:0] stage_hex_q, stage_hex_d;
  logic [7:0]      stage_dp_q, stage_dp_d;
  logic [7:0]      stage_off_q, stage_off_d;
  logic [7:0]      stage_bad_q, stage_bad_d;

  logic [31:0]     hex_q;
  logic [7:0]      dp_out_q, off_out_q, bad_out_q;
  logic            frame_vld_q, err_q;

  logic            an_idle, an_valid, an_illegal;
  logic [3:0]      zero_cnt;
  logic [2:0]      dig_idx;
  logic            win_stable;
  logic            cap, clr_mask, ill_err, fire, err_d;
  logic [5:0]      dec;

  // Returns {bad, off, nibble} for an active-high {g..a} pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h3F:   decode_seg = {2'b00, 4'h0};
      7'h06:   decode_seg = {2'b00, 4'h1};
      7'h5B:   decode_seg = {2'b00, 4'h2};
      7'h4F:   decode_seg = {2'b00, 4'h3};
      7'h66:   decode_seg = {2'b00, 4'h4};
      7'h6D:   decode_seg = {2'b00, 4'h5};
      7'h7D:   decode_seg = {2'b00, 4'h6};
      7'h07:   decode_seg = {2'b00, 4'h7};
      7'h7F:   decode_seg = {2'b00, 4'h8};
      7'h6F:   decode_seg = {2'b00, 4'h9};
      7'h77:   decode_seg = {2'b00, 4'hA};
      7'h7C:   decode_seg = {2'b00, 4'hB};
      7'h39:   decode_seg = {2'b00, 4'hC};
      7'h5E:   decode_seg = {2'b00, 4'hD};
      7'h79:   decode_seg = {2'b00, 4'hE};
      7'h71:   decode_seg = {2'b00, 4'hF};
      7'h00:   decode_seg = {2'b01, 4'h0};
      default: decode_seg = {2'b10, 4'h0};
    endcase
  endfunction

  // Line sampling; the FSM always works on the registered copy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      an_s_q    <= '1;
      an_prev_q <= '1;
      seg_s_q   <= '0;
      dp_s_q    <= 1'b0;
    end else if (SMP_CE) begin
      an_s_q    <= AN;
      an_prev_q <= an_s_q;
      seg_s_q   <= ~{CG, CF, CE, CD, CC, CB, CA};
      dp_s_q    <= ~DP;
    end
  end

`ifdef DISP_CAP_STABLE_EN
  logic [6:0] seg_prev_q;
  logic       dp_prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_prev_q <= '0;
      dp_prev_q  <= 1'b0;
    end else if (SMP_CE) begin
      seg_prev_q <= seg_s_q;
      dp_prev_q  <= dp_s_q;
    end
  end

  assign win_stable = (seg_s_q == seg_prev_q) && (dp_s_q == dp_prev_q);
`else
  assign win_stable = 1'b1;
`endif

  always_comb begin
    zero_cnt = '0;
    dig_idx  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!an_s_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        dig_idx  = 3'(i);
      end
    end
    an_idle    = (an_s_q == '1);
    an_valid   = (zero_cnt == 4'd1);
    an_illegal = !an_idle && !an_valid;
  end

  assign cnt_inc = cnt_q + 4'd1;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (SMP_CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap      = 1'b0;
    clr_mask = 1'b0;
    ill_err  = 1'b0;
    if (an_illegal) begin
      ill_err  = 1'b1;
      clr_mask = 1'b1;
      state_d  = S_IDLE;
      cnt_d    = '0;
    end else if (an_idle) begin
      clr_mask = 1'b1;
      state_d  = S_IDLE;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
        S_SETTLE: begin
          if (an_s_q != an_prev_q) begin
            cnt_d = '0;
          end else if (!win_stable) begin
            cnt_d = '0;
          end else if (cnt_inc == 4'(SETTLE_CNT)) begin
            cap     = 1'b1;
            state_d = S_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_HOLD: begin
          if (an_s_q != an_prev_q) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output / datapath logic; the completing digit is merged before the frame is published.
  always_comb begin
    dec         = decode_seg(seg_s_q);
    mask_set    = mask_q | (8'd1 << dig_idx);
    fire        = cap && (mask_set == '1);
    err_d       = ill_err || (cap && dec[5]);
    stage_hex_d = stage_hex_q;
    stage_dp_d  = stage_dp_q;
    stage_off_d = stage_off_q;
    stage_bad_d = stage_bad_q;
    mask_d      = mask_q;
    if (cap) begin
      stage_hex_d[dig_idx] = dec[3:0];
      stage_dp_d[dig_idx]  = dp_s_q;
      stage_off_d[dig_idx] = dec[4];
      stage_bad_d[dig_idx] = dec[5];
      mask_d               = fire ? '0 : mask_set;
    end
    if (clr_mask) begin
      mask_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q      <= '0;
      stage_hex_q <= '0;
      stage_dp_q  <= '0;
      stage_off_q <= '0;
      stage_bad_q <= '0;
      hex_q       <= '0;
      dp_out_q    <= '0;
      off_out_q   <= '0;
      bad_out_q   <= '0;
      frame_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      frame_vld_q <= 1'b0;
      err_q       <= 1'b0;
      if (SMP_CE) begin
        mask_q      <= mask_d;
        stage_hex_q <= stage_hex_d;
        stage_dp_q  <= stage_dp_d;
        stage_off_q <= stage_off_d;
        stage_bad_q <= stage_bad_d;
        frame_vld_q <= fire;
        err_q       <= err_d;
        if (fire) begin
          hex_q     <= stage_hex_d;
          dp_out_q  <= stage_dp_d;
          off_out_q <= stage_off_d;
          bad_out_q <= stage_bad_d;
        end
      end
    end
  end

  assign HEX_OUT   = hex_q;
  assign DP_OUT    = dp_out_q;
  assign OFF_OUT   = off_out_q;
  assign BAD_OUT   = bad_out_q;
  assign FRAME_VLD = frame_vld_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_disp_scan_capture.sv
// Directed bench for disp_scan_capture: frame decode, blank/bad digits, illegal anodes,
// mid-frame reset and segment changes inside the settle window.
module tb_disp_scan_capture;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SMP_CE = 1'b0;
  logic [7:0]  AN = 8'hFF;
  logic        CA = 1'b1, CB = 1'b1, CC = 1'b1, CD = 1'b1, CE = 1'b1, CF = 1'b1, CG = 1'b1;
  logic        DP = 1'b1;
  logic [31:0] HEX_OUT;
  logic [7:0]  DP_OUT, OFF_OUT, BAD_OUT;
  logic        FRAME_VLD, ERR;

  int n_cmp = 0;
  int n_bad = 0;
  int frames = 0;
  int errs = 0;

  disp_scan_capture #(.SETTLE_CNT(2)) dut (
    .CLK(CLK), .RST(RST), .SMP_CE(SMP_CE), .AN(AN),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP),
    .HEX_OUT(HEX_OUT), .DP_OUT(DP_OUT), .OFF_OUT(OFF_OUT), .BAD_OUT(BAD_OUT),
    .FRAME_VLD(FRAME_VLD), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_VLD) frames++;
    if (ERR) errs++;
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F; 4'h1: seg7 = 7'h06; 4'h2: seg7 = 7'h5B; 4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66; 4'h5: seg7 = 7'h6D; 4'h6: seg7 = 7'h7D; 4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F; 4'h9: seg7 = 7'h6F; 4'hA: seg7 = 7'h77; 4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39; 4'hD: seg7 = 7'h5E; 4'hE: seg7 = 7'h79; default: seg7 = 7'h71;
    endcase
  endfunction

  task automatic sample();
    SMP_CE = 1'b1;
    @(posedge CLK); #1;
    SMP_CE = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic show(input int k, input logic [6:0] pat, input logic dpv, input int n);
    AN = ~(8'd1 << k);
    {CG, CF, CE, CD, CC, CB, CA} = ~pat;
    DP = ~dpv;
    repeat (n) sample();
  endtask

  task automatic scan_range(input logic [31:0] v, input logic [7:0] dpm, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) show(k, seg7(v[4*k +: 4]), dpm[k], 4);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    n_cmp += 6;
    if (HEX_OUT !== 32'h0) begin n_bad++; $display("FAIL reset_hex got=%h exp=0", HEX_OUT); end
    if (DP_OUT !== 8'h0) begin n_bad++; $display("FAIL reset_dp got=%h exp=0", DP_OUT); end
    if (OFF_OUT !== 8'h0) begin n_bad++; $display("FAIL reset_off got=%h exp=0", OFF_OUT); end
    if (BAD_OUT !== 8'h0) begin n_bad++; $display("FAIL reset_bad got=%h exp=0", BAD_OUT); end
    if (FRAME_VLD !== 1'b0) begin n_bad++; $display("FAIL reset_vld got=%b exp=0", FRAME_VLD); end
    if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", ERR); end
  endtask

  task automatic test_basic_frame();
    int f0 = frames, e0 = errs;
    scan_range(32'h12345678, 8'h05, 0, 6);
    n_cmp++;
    if (frames != f0) begin n_bad++; $display("FAIL basic_early got=%0d exp=0", frames - f0); end
    scan_range(32'h12345678, 8'h05, 7, 7);
    n_cmp += 6;
    if (frames != f0 + 1) begin n_bad++; $display("FAIL basic_frames got=%0d exp=1", frames - f0); end
    if (HEX_OUT !== 32'h12345678) begin n_bad++; $display("FAIL basic_hex got=%h exp=12345678", HEX_OUT); end
    if (DP_OUT !== 8'h05) begin n_bad++; $display("FAIL basic_dp got=%h exp=05", DP_OUT); end
    if (OFF_OUT !== 8'h00) begin n_bad++; $display("FAIL basic_off got=%h exp=00", OFF_OUT); end
    if (BAD_OUT !== 8'h00) begin n_bad++; $display("FAIL basic_bad got=%h exp=00", BAD_OUT); end
    if (errs != e0) begin n_bad++; $display("FAIL basic_err got=%0d exp=0", errs - e0); end
  endtask

  task automatic test_blank_digit();
    logic [31:0] v = 32'hA5C3E0F1;
    int f0 = frames;
    for (int k = 0; k < 8; k++) show(k, (k == 3) ? 7'h00 : seg7(v[4*k +: 4]), 1'b0, 4);
    n_cmp += 5;
    if (frames != f0 + 1) begin n_bad++; $display("FAIL blank_frames got=%0d exp=1", frames - f0); end
    if (HEX_OUT !== 32'hA5C300F1) begin n_bad++; $display("FAIL blank_hex got=%h exp=a5c300f1", HEX_OUT); end
    if (OFF_OUT !== 8'h08) begin n_bad++; $display("FAIL blank_off got=%h exp=08", OFF_OUT); end
    if (BAD_OUT !== 8'h00) begin n_bad++; $display("FAIL blank_bad got=%h exp=00", BAD_OUT); end
    if (DP_OUT !== 8'h00) begin n_bad++; $display("FAIL blank_dp got=%h exp=00", DP_OUT); end
  endtask

  task automatic test_bad_pattern();
    logic [31:0] v = 32'h87654321;
    int f0 = frames, e0 = errs;
    for (int k = 0; k < 6; k++) show(k, seg7(v[4*k +: 4]), 1'b0, 4);
    show(6, 7'h49, 1'b0, 4);
    n_cmp++;
    if (errs != e0 + 1) begin n_bad++; $display("FAIL bad_err_pulse got=%0d exp=1", errs - e0); end
    show(7, seg7(v[31:28]), 1'b0, 4);
    n_cmp += 4;
    if (frames != f0 + 1) begin n_bad++; $display("FAIL bad_frames got=%0d exp=1", frames - f0); end
    if (HEX_OUT !== 32'h80654321) begin n_bad++; $display("FAIL bad_hex got=%h exp=80654321", HEX_OUT); end
    if (BAD_OUT !== 8'h40) begin n_bad++; $display("FAIL bad_mask got=%h exp=40", BAD_OUT); end
    if (OFF_OUT !== 8'h00) begin n_bad++; $display("FAIL bad_off got=%h exp=00", OFF_OUT); end
  endtask

  task automatic test_illegal_anode();
    logic [31:0] v = 32'h0F1E2D3C;
    int f0 = frames, e0 = errs;
    scan_range(32'hDEADBEEF, 8'hFF, 0, 3);
    AN = 8'b1111_0011;
    sample();
    scan_range(v, 8'h3C, 4, 7);
    n_cmp += 2;
    if (errs != e0 + 1) begin n_bad++; $display("FAIL illegal_err got=%0d exp=1", errs - e0); end
    if (frames != f0) begin n_bad++; $display("FAIL illegal_mask_kept got=%0d exp=0", frames - f0); end
    scan_range(v, 8'h3C, 0, 2);
    n_cmp++;
    if (frames != f0) begin n_bad++; $display("FAIL illegal_seven got=%0d exp=0", frames - f0); end
    scan_range(v, 8'h3C, 3, 3);
    n_cmp += 3;
    if (frames != f0 + 1) begin n_bad++; $display("FAIL illegal_frames got=%0d exp=1", frames - f0); end
    if (HEX_OUT !== v) begin n_bad++; $display("FAIL illegal_hex got=%h exp=%h", HEX_OUT, v); end
    if (DP_OUT !== 8'h3C) begin n_bad++; $display("FAIL illegal_dp got=%h exp=3c", DP_OUT); end
  endtask

  task automatic test_reset_midframe();
    int f0 = frames;
    scan_range(32'h11111111, 8'hFF, 0, 4);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_cmp += 4;
    if (HEX_OUT !== 32'h0) begin n_bad++; $display("FAIL rst_hex got=%h exp=0", HEX_OUT); end
    if (DP_OUT !== 8'h0) begin n_bad++; $display("FAIL rst_dp got=%h exp=0", DP_OUT); end
    if (BAD_OUT !== 8'h0) begin n_bad++; $display("FAIL rst_bad got=%h exp=0", BAD_OUT); end
    if (frames != f0) begin n_bad++; $display("FAIL rst_frames got=%0d exp=0", frames - f0); end
    scan_range(32'h89ABCDEF, 8'hA0, 0, 7);
    n_cmp += 3;
    if (frames != f0 + 1) begin n_bad++; $display("FAIL rst_next_frames got=%0d exp=1", frames - f0); end
    if (HEX_OUT !== 32'h89ABCDEF) begin n_bad++; $display("FAIL rst_next_hex got=%h exp=89abcdef", HEX_OUT); end
    if (DP_OUT !== 8'hA0) begin n_bad++; $display("FAIL rst_next_dp got=%h exp=a0", DP_OUT); end
  endtask

  task automatic test_seg_change();
    int f0 = frames;
    scan_range(32'h55555555, 8'h00, 0, 6);
`ifdef DISP_CAP_STABLE_EN
    show(7, seg7(4'h1), 1'b0, 1);
    show(7, seg7(4'h9), 1'b0, 3);
    n_cmp++;
    if (frames != f0) begin n_bad++; $display("FAIL stable_delay got=%0d exp=0", frames - f0); end
    show(7, seg7(4'h9), 1'b0, 1);
`else
    show(7, seg7(4'h1), 1'b0, 2);
    show(7, seg7(4'h9), 1'b0, 1);
    n_cmp++;
    if (frames != f0) begin n_bad++; $display("FAIL segchg_early got=%0d exp=0", frames - f0); end
    show(7, seg7(4'h5), 1'b0, 1);
`endif
    n_cmp += 2;
    if (frames != f0 + 1) begin n_bad++; $display("FAIL segchg_frames got=%0d exp=1", frames - f0); end
    if (HEX_OUT !== 32'h95555555) begin n_bad++; $display("FAIL segchg_hex got=%h exp=95555555", HEX_OUT); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_blank_digit();
    test_bad_pattern();
    test_illegal_anode();
    test_reset_midframe();
    test_seg_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
